// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory address, prefetch FIFO.
// Hands fetched words (or a fault marker) to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 800,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fetch_unit: DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];

  logic   pop;
  logic   fetch_en;
  logic   fault;
  entry_t head;
  entry_t new_entry;

  assign mem_address = pc_q;
  assign head        = fifo_q[rd_ptr_q];
  assign inst_valid  = (count_q != '0);
  assign inst_data   = inst_valid ? head.word  : 32'h0;
  assign inst_pc     = inst_valid ? head.pc    : 32'h0;
  assign inst_fault  = inst_valid ? head.fault : 1'b0;

  // Handshake, fault detection and fetch enable for this cycle.
  always_comb begin
    pop   = inst_valid & inst_ready;
    fault = (pc_q > LAST_PC) | (pc_q[1:0] != 2'b00);
    fetch_en = (state_q == RUN) & ~mem_busy & ~redirect_valid &
               ((count_q < FULL) | pop);
    new_entry.pc    = pc_q;
    new_entry.word  = fault ? 32'h0 : mem_read_data;
    new_entry.fault = fault;
  end

  // Next-state: redirect flushes everything, else pop/push the FIFO.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fifo_d   = fifo_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = redirect_pc;
      state_d  = RUN;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (fetch_en) begin
        fifo_d[wr_ptr_q] = new_entry;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (fault) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      unique case ({fetch_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the FIFO and reloads the PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fifo_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic,
// checked against a queue-based model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned MEM_BYTES = 800;
  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] GARBAGE   = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .MEM_BYTES(MEM_BYTES),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data),
    .mem_busy      (mem_busy),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [MEM_BYTES/4];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a <= 32'(MEM_BYTES - 4) && a[1:0] == 2'b00)
      return rom[a[31:2]];
    return GARBAGE;
  endfunction

  always_comb mem_read_data = rd_word(mem_address);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input bit rdy, input bit bsy,
                            input bit rv, input logic [31:0] rpc);
    bit   pop;
    bit   fe;
    bit   flt;
    ent_t e;
    pop = (mq.size() != 0) && rdy;
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      fe = !m_halt && !bsy && (mq.size() < DEPTH || pop);
      if (pop) void'(mq.pop_front());
      if (fe) begin
        flt = (m_pc > MEM_BYTES - 4) || (m_pc % 4 != 0);
        e.pc    = m_pc;
        e.word  = flt ? 32'h0 : rd_word(m_pc);
        e.fault = flt;
        mq.push_back(e);
        if (flt) m_halt = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all();
    bit ne;
    ne = (mq.size() != 0);
    check("valid", 32'(inst_valid), 32'(ne));
    check("pc", inst_pc, ne ? mq[0].pc : 32'h0);
    check("data", inst_data, ne ? mq[0].word : 32'h0);
    check("fault", 32'(inst_fault), ne ? 32'(mq[0].fault) : 32'h0);
    check("addr", mem_address, m_pc);
  endtask

  task automatic cyc(input bit rdy, input bit bsy,
                     input bit rv, input logic [31:0] rpc);
    inst_ready     = rdy;
    mem_busy       = bsy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step(rdy, bsy, rv, rpc);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_addr", mem_address, RESET_PC);
    inst_ready     = 1'b0;
    mem_busy       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    compare_all();
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 6))
      0: return 32'd792;
      1: return 32'd796;
      2: return 32'd800;
      3: return 32'($urandom_range(0, 199) * 4 + $urandom_range(1, 3));
      4: return 32'hFFFF_FFFC;
      default: return 32'($urandom_range(0, 199) * 4);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MEM_BYTES / 4; i++) rom[i] = $urandom;
    rom[0] = 32'hE3A00000;
    rom[1] = 32'hE2800001;
    rom[4] = 32'hE1A00000;

    reset = 1'b1;
    inst_ready = 1'b0;
    mem_busy = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming after reset with decode always ready.
    cyc(1, 0, 0, 0);
    check("first_pc", inst_pc, 32'h0);
    check("first_data", inst_data, 32'hE3A00000);
    cyc(1, 0, 0, 0);
    check("second_pc", inst_pc, 32'h4);
    check("second_data", inst_data, 32'hE2800001);
    repeat (6) cyc(1, 0, 0, 0);

    // Back-pressure: FIFO fills, PC stops at 8, then drains with no bubble.
    do_reset();
    repeat (5) cyc(0, 0, 0, 0);
    check("bp_addr", mem_address, 32'h8);
    check("bp_head", inst_pc, 32'h0);
    cyc(1, 0, 0, 0);
    check("bp_next", inst_pc, 32'h4);
    cyc(1, 0, 0, 0);
    check("bp_third", inst_pc, 32'h8);
    repeat (3) cyc(1, 0, 0, 0);

    // Memory busy in the third cycle.
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("busy_bubble", 32'(inst_valid), 32'h0);
    cyc(1, 0, 0, 0);
    check("busy_resume", inst_pc, 32'h8);
    repeat (3) cyc(1, 0, 0, 0);

    // Redirect with two entries queued.
    do_reset();
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'd16);
    check("redir_flush", 32'(inst_valid), 32'h0);
    cyc(1, 0, 0, 0);
    check("redir_pc", inst_pc, 32'd16);
    check("redir_data", inst_data, 32'hE1A00000);

    // Redirect near the top of memory: last word, then a fault marker.
    cyc(0, 0, 1, 32'd796);
    repeat (4) cyc(0, 0, 0, 0);
    check("top_addr", mem_address, 32'd800);
    cyc(1, 0, 0, 0);
    check("top_fault_pc", inst_pc, 32'd800);
    check("top_fault", 32'(inst_fault), 32'h1);
    check("top_fault_data", inst_data, 32'h0);
    repeat (3) cyc(1, 0, 0, 0);
    check("halt_empty", 32'(inst_valid), 32'h0);
    cyc(1, 0, 1, 32'd0);
    cyc(1, 0, 0, 0);
    check("resume_pc", inst_pc, 32'h0);

    // Misaligned target faults immediately.
    cyc(0, 0, 1, 32'd6);
    cyc(0, 0, 0, 0);
    check("misalign_fault", 32'(inst_fault), 32'h1);

    // Async reset while halted with two entries held.
    cyc(0, 0, 1, 32'd796);
    repeat (3) cyc(0, 0, 0, 0);
    check("pre_rst_valid", 32'(inst_valid), 32'h1);
    do_reset();
    cyc(1, 0, 0, 0);
    check("post_rst_pc", inst_pc, RESET_PC);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rv;
      rv = ($urandom_range(0, 99) < 6);
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
          rv, rv ? rand_target() : 32'($urandom));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
